// File: rtl/pc_btb_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator and its branch target buffer.
// Holds the reset vector, default address width and 2-bit counter encodings.
package pc_btb_gen_pkg;

  localparam int unsigned ADDR_SIZE_DEF   = 32;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h8000_0000;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Saturating step: strong states absorb further training in their own direction.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken && (c != CTR_ST)) begin
      r = ctr_t'(c + 2'd1);
    end else if (!taken && (c != CTR_SNT)) begin
      r = ctr_t'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_btb_table.sv
// Direct-mapped BTB: valid/tag/target/counter arrays with a combinational read port
// and a synchronous training port. Only the valid bits are reset.
module pc_btb_table
  import pc_btb_gen_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = ADDR_SIZE_DEF,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned IDX_BITS    = $clog2(BTB_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_SIZE-1:0] lookup_pc,
  output logic                 hit,
  output ctr_t                 ctr,
  output logic [ADDR_SIZE-1:0] target,
  input  logic                 upd_valid,
  input  logic [ADDR_SIZE-1:0] upd_pc,
  input  logic [ADDR_SIZE-1:0] upd_target,
  input  logic                 upd_taken
);

  localparam int unsigned TAG_BITS = ADDR_SIZE - IDX_BITS - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_BITS-1:0]    tag_q    [BTB_ENTRIES];
  logic [ADDR_SIZE-1:0]   target_q [BTB_ENTRIES];
  ctr_t                   ctr_q    [BTB_ENTRIES];

  logic [IDX_BITS-1:0] rd_idx, upd_idx;
  logic [TAG_BITS-1:0] rd_tag, upd_tag;
  logic                upd_hit;
  logic                upd_alloc;
  logic                unused_byte_offset;

  assign rd_idx  = lookup_pc[IDX_BITS+1:2];
  assign rd_tag  = lookup_pc[ADDR_SIZE-1:IDX_BITS+2];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[ADDR_SIZE-1:IDX_BITS+2];

  // Instructions are word aligned, so the byte offset never selects an entry.
  assign unused_byte_offset = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Read port sees pre-update contents; there is deliberately no bypass.
  assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign ctr    = ctr_q[rd_idx];
  assign target = target_q[rd_idx];

  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_alloc = upd_valid && !upd_hit && upd_taken;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (upd_alloc) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next(ctr_q[upd_idx], upd_taken);
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/pc_btb_gen.sv
// Fetch PC register with next-PC selection: redirect, BTB prediction, or hold.
// Predicts from the registered PC through a direct-mapped BTB.
module pc_btb_gen
  import pc_btb_gen_pkg::*;
#(
  parameter int unsigned          ADDR_SIZE    = ADDR_SIZE_DEF,
  parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = ADDR_SIZE'(PC_RESET_VECTOR),
  parameter int unsigned          BTB_ENTRIES  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 redirect_valid,
  input  logic [ADDR_SIZE-1:0] redirect_pc,
  input  logic                 upd_valid,
  input  logic [ADDR_SIZE-1:0] upd_pc,
  input  logic [ADDR_SIZE-1:0] upd_target,
  input  logic                 upd_taken,
  output logic [ADDR_SIZE-1:0] pc,
  output logic [ADDR_SIZE-1:0] pc_plus4,
  output logic                 pred_taken,
  output logic [ADDR_SIZE-1:0] pred_target
);

  localparam int unsigned IDX_BITS = $clog2(BTB_ENTRIES);

  logic [ADDR_SIZE-1:0] pc_q;
  logic                 btb_hit;
  ctr_t                 btb_ctr;
  logic [ADDR_SIZE-1:0] btb_target;

  pc_btb_table #(
    .ADDR_SIZE  (ADDR_SIZE),
    .BTB_ENTRIES(BTB_ENTRIES),
    .IDX_BITS   (IDX_BITS)
  ) u_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .lookup_pc (pc_q),
    .hit       (btb_hit),
    .ctr       (btb_ctr),
    .target    (btb_target),
    .upd_valid (upd_valid),
    .upd_pc    (upd_pc),
    .upd_target(upd_target),
    .upd_taken (upd_taken)
  );

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + ADDR_SIZE'(4);
  assign pred_taken  = btb_hit && btb_ctr[1];
  // Stored targets keep bit 0 as trained; the fetch address never carries it.
  assign pred_target = pred_taken ? (btb_target & ~ADDR_SIZE'(1)) : pc_plus4;

  // Redirect beats stall: a resolved mispredict must land even while fetch is frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_VECTOR;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ~ADDR_SIZE'(1);
    end else if (en) begin
      pc_q <= pred_target;
    end
  end

endmodule

// File: tb/tb_pc_btb_gen.sv
// Directed bench for pc_btb_gen: expected {pc, pred_taken, pred_target, pc_plus4}
// tuples are queued as each step is driven and popped when the DUT state is sampled.
module tb_pc_btb_gen;

  localparam int W = 97;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  pc_btb_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected tuple: pc, predicted direction, next fetch address, pc + 4.
  function automatic logic [W-1:0] ex(input logic [31:0] p, input logic t, input logic [31:0] tg);
    logic [31:0] p4;
    p4 = p + 32'd4;
    return {p, t, (t ? tg : p4), p4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic rv, input logic [31:0] rp,
                       input logic uv, input logic [31:0] up, input logic [31:0] ut,
                       input logic tk);
    en             = e;
    redirect_valid = rv;
    redirect_pc    = rp;
    upd_valid      = uv;
    upd_pc         = up;
    upd_target     = ut;
    upd_taken      = tk;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic chk(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    obs = {pc, pred_taken, pred_target, pc_plus4};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_err++;
        $error("FAIL %s: observed pc=%h pt=%b tgt=%h p4=%h expected pc=%h pt=%b tgt=%h p4=%h",
               tag, obs[96:65], obs[64], obs[63:32], obs[31:0],
               exp_v[96:65], exp_v[64], exp_v[63:32], exp_v[31:0]);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    reset_n = 1'b0;
    repeat (2) tick();
    exp_q.push_back(ex(32'h8000_0000, 1'b0, 32'h0));
    chk("reset");

    // Release and free-run sequentially.
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_q.push_back(ex(32'h8000_0004, 1'b0, 32'h0)); tick(); chk("seq_4");
    exp_q.push_back(ex(32'h8000_0008, 1'b0, 32'h0)); tick(); chk("seq_8");
    exp_q.push_back(ex(32'h8000_000C, 1'b0, 32'h0)); tick(); chk("seq_c");

    // Train taken branch at 80000010; its first lookup already hits.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1);
    exp_q.push_back(ex(32'h8000_0010, 1'b1, 32'h8000_0100)); tick(); chk("train_hit");
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_q.push_back(ex(32'h8000_0100, 1'b0, 32'h0)); tick(); chk("follow_pred");

    // Saturation: three taken (10->11->11->11), then not-taken steps down.
    drive(1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1);
    exp_q.push_back(ex(32'h8000_0010, 1'b1, 32'h8000_0100)); tick(); chk("sat_t1");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1);
    exp_q.push_back(ex(32'h8000_0010, 1'b1, 32'h8000_0100)); tick(); chk("sat_t2");
    exp_q.push_back(ex(32'h8000_0010, 1'b1, 32'h8000_0100)); tick(); chk("sat_t3");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0010, 32'h8000_0bad, 1'b0);
    exp_q.push_back(ex(32'h8000_0010, 1'b1, 32'h8000_0100)); tick(); chk("sat_nt1");
    exp_q.push_back(ex(32'h8000_0010, 1'b0, 32'h0)); tick(); chk("sat_nt2");
    exp_q.push_back(ex(32'h8000_0010, 1'b0, 32'h0)); tick(); chk("sat_nt3");
    exp_q.push_back(ex(32'h8000_0010, 1'b0, 32'h0)); tick(); chk("sat_floor");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1);
    exp_q.push_back(ex(32'h8000_0010, 1'b0, 32'h0)); tick(); chk("sat_up_wnt");

    // Stall holds; redirect overrides stall and clears bit 0.
    drive(1'b0, 1'b1, 32'h8000_0020, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_q.push_back(ex(32'h8000_0020, 1'b0, 32'h0)); tick(); chk("redir_20");
    idle();
    exp_q.push_back(ex(32'h8000_0020, 1'b0, 32'h0)); tick(); chk("stall_hold");
    drive(1'b0, 1'b1, 32'h8000_0203, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_q.push_back(ex(32'h8000_0202, 1'b0, 32'h0)); tick(); chk("redir_stall");

    // Aliasing: 80000010 back to weak-T, then look up 80000050 (same index).
    drive(1'b0, 1'b1, 32'h8000_0050, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b1);
    exp_q.push_back(ex(32'h8000_0050, 1'b0, 32'h0)); tick(); chk("alias_miss");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0050, 32'h8000_0401, 1'b1);
    exp_q.push_back(ex(32'h8000_0050, 1'b1, 32'h8000_0400)); tick(); chk("alias_alloc");
    drive(1'b1, 1'b1, 32'h8000_0010, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_q.push_back(ex(32'h8000_0010, 1'b0, 32'h0)); tick(); chk("alias_evicted");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0010, 32'h8000_0100, 1'b0);
    exp_q.push_back(ex(32'h8000_0010, 1'b0, 32'h0)); tick(); chk("miss_nt_noalloc");

    // Wrap past top of address space.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_q.push_back(ex(32'hFFFF_FFFC, 1'b0, 32'h0)); tick(); chk("wrap_top");
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_q.push_back(ex(32'h0000_0000, 1'b0, 32'h0)); tick(); chk("wrap_zero");

    // Same-cycle update and lookup: old prediction now, new one next cycle.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'h0000_0800, 1'b1);
    exp_q.push_back(ex(32'h0000_0000, 1'b0, 32'h0)); chk("coll_old");
    exp_q.push_back(ex(32'h0000_0000, 1'b1, 32'h0000_0800)); tick(); chk("coll_new");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'h0000_0900, 1'b1);
    exp_q.push_back(ex(32'h0000_0000, 1'b1, 32'h0000_0800)); chk("retarget_old");
    exp_q.push_back(ex(32'h0000_0000, 1'b1, 32'h0000_0900)); tick(); chk("retarget_new");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'h0000_1234, 1'b0);
    exp_q.push_back(ex(32'h0000_0000, 1'b1, 32'h0000_0900)); tick(); chk("nt_keeps_target");

    // Asynchronous reset mid-cycle with an update pending.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'h0000_0900, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(ex(32'h8000_0000, 1'b0, 32'h0)); chk("async_reset");
    tick();
    exp_q.push_back(ex(32'h8000_0000, 1'b0, 32'h0)); chk("reset_held");
    reset_n = 1'b1;
    drive(1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_q.push_back(ex(32'h0000_0000, 1'b0, 32'h0)); tick(); chk("valid_cleared");

    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
